// File: rtl/pc_fetch_queue.sv
// rtl/pc_fetch_queue.sv - fetch stage: PC, redirect target generation and prefetch queue
module pc_fetch_queue #(
   parameter int                ADDR_W    = 32,
   parameter int                INSTR_W   = 32,
   parameter int                DEPTH     = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   input  logic                       redirect_valid,
   input  logic [1:0]                 redirect_sel,
   input  logic [ADDR_W-1:0]          redirect_pc4,
   input  logic [15:0]                redirect_imm,
   input  logic [25:0]                redirect_jidx,
   input  logic [ADDR_W-1:0]          redirect_reg,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSTR_W-1:0]         out_instr,
   output logic [ADDR_W-1:0]          out_pc,
   output logic [ADDR_W-1:0]          out_pc4,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic                       misalign
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               misalign_q, misalign_d;

   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0]  pc_q    [DEPTH];

   logic               pop;
   logic               push;
   logic [31:0]        br_off32;
   logic [ADDR_W-1:0]  br_tgt;
   logic [ADDR_W-1:0]  jmp_tgt;
   logic [ADDR_W-1:0]  tgt;
   logic [ADDR_W-1:0]  head_pc;

   // Branch offset is a signed word count; widen to 32 bits before scaling.
   assign br_off32 = {{14{redirect_imm[15]}}, redirect_imm, 2'b00};
   assign br_tgt   = redirect_pc4 + br_off32[ADDR_W-1:0];

   // Jump keeps the upper PC region only when the PC is wider than the 28-bit jump span.
   generate
      if (ADDR_W > 28) begin : g_jmp_wide
         assign jmp_tgt = {redirect_pc4[ADDR_W-1:28], redirect_jidx, 2'b00};
      end else begin : g_jmp_narrow
         logic [27:0] jfull;
         assign jfull   = {redirect_jidx, 2'b00};
         assign jmp_tgt = jfull[ADDR_W-1:0];
      end
   endgenerate

   // Redirect target select; the reserved encoding behaves as register.
   always_comb begin
      tgt = redirect_reg;
      case (redirect_sel)
         2'b00:   tgt = br_tgt;
         2'b01:   tgt = jmp_tgt;
         default: tgt = redirect_reg;
      endcase
   end

   assign pop  = (occ_q != '0) & out_ready;
   assign push = !redirect_valid & ((occ_q != DEPTH_C) | pop);

   // Next-state: a redirect flushes everything and wins over push and pop.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      occ_d      = occ_q;
      misalign_d = 1'b0;
      if (redirect_valid) begin
         fetch_pc_d = {tgt[ADDR_W-1:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         occ_d      = '0;
         misalign_d = (tgt[1:0] != 2'b00);
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_VEC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         occ_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         occ_q      <= occ_d;
         misalign_q <= misalign_d;
      end
   end

   // Queue storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr_q] <= imem_rdata;
         pc_q[wr_ptr_q]    <= fetch_pc_q;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign occupancy = occ_q;
   assign misalign  = misalign_q;
   assign out_valid = (occ_q != '0);
   assign head_pc   = pc_q[rd_ptr_q];

   // Head fields read zero whenever the queue is empty, including during reset.
   assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? head_pc : '0;
   assign out_pc4   = out_valid ? (head_pc + ADDR_W'(4)) : '0;

endmodule

// File: tb/tb_pc_fetch_queue.sv
// tb/tb_pc_fetch_queue.sv - self-checking bench for pc_fetch_queue
module tb_pc_fetch_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [1:0]  redirect_sel;
   logic [31:0] redirect_pc4;
   logic [15:0] redirect_imm;
   logic [25:0] redirect_jidx;
   logic [31:0] redirect_reg;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc4;
   logic [2:0]  occupancy;
   logic        misalign;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] m_fpc;
   logic [31:0] m_q[$];
   bit          m_mis;

   pc_fetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_VEC(32'h0)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_sel   (redirect_sel),
      .redirect_pc4   (redirect_pc4),
      .redirect_imm   (redirect_imm),
      .redirect_jidx  (redirect_jidx),
      .redirect_reg   (redirect_reg),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc4        (out_pc4),
      .occupancy      (occupancy),
      .misalign       (misalign)
   );

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] target(input logic [1:0] sel, input logic [31:0] pc4,
                                          input logic [15:0] imm, input logic [25:0] jidx,
                                          input logic [31:0] rg);
      int off;
      off = int'($signed(imm)) * 4;
      case (sel)
         2'b00:   return pc4 + 32'(off);
         2'b01:   return (pc4 & 32'hF000_0000) | (32'(jidx) * 4);
         default: return rg;
      endcase
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".occ"},      32'(occupancy), 32'(m_q.size()));
      check({tag, ".valid"},    32'(out_valid), (m_q.size() != 0) ? 32'd1 : 32'd0);
      check({tag, ".addr"},     imem_addr, m_fpc);
      check({tag, ".misalign"}, 32'(misalign), 32'(m_mis));
      if (m_q.size() != 0) begin
         check({tag, ".pc"},    out_pc, m_q[0]);
         check({tag, ".instr"}, out_instr, m_q[0] ^ 32'hA5A5_0000);
         check({tag, ".pc4"},   out_pc4, m_q[0] + 32'd4);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".occ"},      32'(occupancy), 32'd0);
      check({tag, ".valid"},    32'(out_valid), 32'd0);
      check({tag, ".addr"},     imem_addr, 32'h0);
      check({tag, ".misalign"}, 32'(misalign), 32'd0);
      check({tag, ".pc"},       out_pc, 32'h0);
      check({tag, ".instr"},    out_instr, 32'h0);
      check({tag, ".pc4"},      out_pc4, 32'h0);
   endtask

   // One clock: drive inputs, advance the reference model at the edge, check after it.
   task automatic step(input string tag, input bit rv, input logic [1:0] sel,
                       input logic [31:0] pc4, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic [31:0] rg, input bit rdy);
      logic [31:0] t;
      bit          was_full;
      bit          pp;
      redirect_valid = rv;
      redirect_sel   = sel;
      redirect_pc4   = pc4;
      redirect_imm   = imm;
      redirect_jidx  = jidx;
      redirect_reg   = rg;
      out_ready      = rdy;
      @(posedge clk);
      pp       = (m_q.size() != 0) && rdy;
      was_full = (m_q.size() >= DEPTH);
      if (rv) begin
         t = target(sel, pc4, imm, jidx, rg);
         m_q.delete();
         m_mis = (t % 4) != 0;
         m_fpc = t - (t % 4);
      end else begin
         m_mis = 1'b0;
         if (pp) void'(m_q.pop_front());
         if (!was_full || pp) begin
            m_q.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
         end
      end
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag, input bit rdy);
      step(tag, 1'b0, 2'b00, 32'h0, 16'h0, 26'h0, 32'h0, rdy);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic apply_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset({tag, ".async"});
      @(posedge clk);
      #1;
      check_reset({tag, ".held"});
      #2;
      rst_n = 1'b1;
      m_q.delete();
      m_fpc = 32'h0;
      m_mis = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_sel   = 2'b00;
      redirect_pc4   = '0;
      redirect_imm   = '0;
      redirect_jidx  = '0;
      redirect_reg   = '0;
      out_ready      = 1'b0;
      m_fpc          = 32'h0;
      m_mis          = 1'b0;
      #1;
      check_reset("rst0");
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Streaming with decode always ready.
      for (int i = 0; i < 6; i++) idle("stream", 1'b1);

      // Back-pressure until full, then drain.
      apply_reset("rst1");
      for (int i = 0; i < 8; i++) idle("stall", 1'b0);
      check("stall.addr16", imem_addr, 32'h10);
      check("stall.head0", out_pc, 32'h0);
      for (int i = 0; i < 6; i++) idle("drain", 1'b1);

      // Branch redirect with three entries queued.
      apply_reset("rst2");
      for (int i = 0; i < 3; i++) idle("fill3", 1'b0);
      step("branch", 1'b1, 2'b00, 32'h20, 16'hFFFC, 26'h0, 32'h0, 1'b0);
      check("branch.addr", imem_addr, 32'h10);
      idle("branch1", 1'b0);
      check("branch.head", out_pc, 32'h10);

      // Jump and misaligned register redirect.
      step("jump", 1'b1, 2'b01, 32'h1000_0004, 16'h0, 26'h0000040, 32'h0, 1'b1);
      check("jump.addr", imem_addr, 32'h1000_0100);
      step("reg", 1'b1, 2'b10, 32'h0, 16'h0, 26'h0, 32'h203, 1'b1);
      check("reg.addr", imem_addr, 32'h200);
      check("reg.mis", 32'(misalign), 32'd1);
      idle("reg1", 1'b1);
      check("reg.misclr", 32'(misalign), 32'd0);

      // Redirect together with pop on a full queue, then back-to-back redirects.
      for (int i = 0; i < 5; i++) idle("fill", 1'b0);
      step("rdpop", 1'b1, 2'b11, 32'h0, 16'h0, 26'h0, 32'h300, 1'b1);
      for (int i = 0; i < 3; i++) idle("after", 1'b1);
      step("b2b0", 1'b1, 2'b10, 32'h0, 16'h0, 26'h0, 32'h40, 1'b1);
      step("b2b1", 1'b1, 2'b10, 32'h0, 16'h0, 26'h0, 32'h80, 1'b1);
      idle("b2b2", 1'b1);
      check("b2b.head", out_pc, 32'h80);

      // Mid-stream asynchronous reset and restart.
      apply_reset("rst3");
      idle("restart", 1'b1);
      check("restart.head", out_pc, 32'h0);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         step("rand", ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
              $urandom, 16'($urandom), 26'($urandom), $urandom,
              ($urandom_range(0, 2) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
